bpred_ctrl: RTL and testbench
=============================

# bpred_ctrl

Dynamic branch-prediction controller for the RV32 fetch path: owns a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and answers IF-stage lookups in the same cycle. It sequences table updates from EX-stage branch resolution and generates the registered mispredict redirect. It also runs a table-clear walk on request. Targets live in the fixed 4 KiB text region 0x00400000–0x00400FFF, so only 12-bit target offsets are stored.

## Interface
- ENTRIES, 8 — BTB entries; power of two, 4..64
- IDX_W, 3 — log2(ENTRIES)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_pc  in  32  PC of the instruction in IF
- if_inst  in  32  instruction word in IF
- predict_pc  out  32  next-fetch PC (combinational)
- predict_taken  out  1  IF instruction is predicted taken
- ex_valid  in  1  EX holds a valid instruction
- ex_pc  in  32  PC of the EX instruction
- ex_is_ctrl  in  1  EX instruction is branch/JAL/JALR
- ex_taken  in  1  resolved direction
- ex_target  in  32  resolved target
- ex_pred_taken  in  1  prediction carried down the pipe
- ex_pred_pc  in  32  predicted next PC carried down the pipe
- flush_req  in  1  one-cycle pulse: clear the table
- redirect  out  1  one-cycle mispredict redirect pulse
- redirect_pc  out  32  corrected fetch PC
- busy  out  1  clear walk in progress
- stat_branches  out  16  resolved control instructions (see Configuration)
- stat_mispredicts  out  16  redirects issued (see Configuration)

## Operation
- Entry fields: valid, tag = pc[11:IDX_W+2], target[11:0], cnt[1:0]. Index = pc[IDX_W+1:2].
- Control opcode: inst[6:2] is 11000, 11011 or 11001.
- Lookup hits when the IF instruction is a control opcode, the entry is valid, the tag matches, if_pc[31:12] = 20'h00400, and busy = 0.
- On a hit with cnt[1] = 1: predict_taken = 1, predict_pc = {20'h00400, target}.
- Otherwise: predict_taken = 0, predict_pc = if_pc + 4.
- Mispredict is evaluated when ex_valid = 1:
  - ex_is_ctrl = 1 and ex_taken ≠ ex_pred_taken, or
  - ex_is_ctrl = 1 and ex_taken = ex_pred_taken = 1 and ex_target ≠ ex_pred_pc, or
  - ex_is_ctrl = 0 and ex_pred_taken = 1 (aliased entry).
- Correct PC on a mispredict: ex_target if ex_is_ctrl & ex_taken, else ex_pc + 4.
- Update, applied at the clock edge when ex_valid = 1 and busy = 0:
  - Control instruction, tag hit: cnt increments saturating at 3 if taken, decrements saturating at 0 if not. The target is rewritten when taken.
  - Control instruction, miss, taken: allocate with valid = 1, cnt = 2'b10, new tag and target, overwriting any occupant.
  - Control instruction, miss, not taken: no write.
  - Taken with ex_target[31:12] ≠ 20'h00400: no allocation; a hitting entry is invalidated.
  - Non-control instruction that hits: the entry is invalidated.
- FSM states IDLE and CLR:
  - IDLE → CLR on flush_req. The walk pointer starts at 0 and clears one entry's valid bit per cycle.
  - CLR → IDLE after entry ENTRIES−1 is cleared.
  - busy = 1 in CLR.
  - flush_req received during CLR is ignored.
  - EX updates received during CLR are dropped. Redirects are still generated.

## Timing
- Lookup: zero latency, combinational from if_pc/if_inst and the registered table.
- Table write lands at the edge ending the EX cycle. A same-cycle IF lookup of the same index sees the old contents.
- redirect / redirect_pc: registered, asserted the cycle after the EX cycle, for exactly one cycle.
- Clear walk: busy high for exactly ENTRIES cycles, beginning the cycle after flush_req.
- flush_req coincident with an EX update: the flush wins and the update is dropped.
- Reset values (asynchronous, immediate): all valid = 0, cnt = 0, FSM = IDLE, busy = 0, redirect = 0, redirect_pc = 0, stats = 0.
  - predict_taken = 0 and predict_pc = if_pc + 4 while in reset.
- Reset asserted mid-walk: the walk aborts, the table is fully cleared, and the FSM returns to IDLE.

## Configuration
- BPRED_STATS_EN defined:
  - stat_branches increments once per ex_valid & ex_is_ctrl.
  - stat_mispredicts increments once per redirect pulse.
  - Both saturate at 16'hFFFF, are counted during CLR, and are cleared only by reset.
- BPRED_STATS_EN undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Cold lookup → prediction: reset, then if_pc = 0x0040000C with a BEQ opcode → predict_taken = 0, predict_pc = 0x00400010.
- Allocate and predict: resolve a taken branch at 0x0040000C → 0x00400034 with ex_pred_taken = 0 → next cycle redirect = 1, redirect_pc = 0x00400034. A later IF lookup of 0x0040000C → predict_taken = 1, predict_pc = 0x00400034.
- Counter hysteresis: from cnt = 2'b10, resolve one not-taken → redirect to 0x00400010, cnt = 1, and the next lookup predicts not-taken. Two taken resolutions then give cnt = 3.
- Clear walk with a dropped update: allocate entries, pulse flush_req, and present a taken EX update in the same cycle → busy high for 8 cycles, the update is dropped, and all lookups afterwards miss.
- Alias invalidation: ex_is_ctrl = 0 with ex_pred_taken = 1 at 0x00400024 → redirect_pc = 0x00400028 and the entry is invalidated.
- Stats (BPRED_STATS_EN defined): 5 resolved branches with 2 mispredicts → stat_branches = 5, stat_mispredicts = 2. With the macro undefined, both read 0.

Source files
------------

// File: rtl/bpred_ctrl_if.sv
// bpred_ctrl_if: fetch-path bundle between pipeline and branch predictor.
// master = pipeline side (IF/EX/flush drivers), slave = predictor side.
interface bpred_ctrl_if;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] predict_pc;
  logic        predict_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_ctrl;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_pc;
  logic        flush_req;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;

  modport master (
    output if_pc, if_inst,
    output ex_valid, ex_pc, ex_is_ctrl, ex_taken,
    output ex_target, ex_pred_taken, ex_pred_pc,
    output flush_req,
    input  predict_pc, predict_taken,
    input  redirect, redirect_pc, busy,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, if_inst,
    input  ex_valid, ex_pc, ex_is_ctrl, ex_taken,
    input  ex_target, ex_pred_taken, ex_pred_pc,
    input  flush_req,
    output predict_pc, predict_taken,
    output redirect, redirect_pc, busy,
    output stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bpred_ctrl.sv
// bpred_ctrl: direct-mapped BTB + 2-bit counters, EX update, redirect, clear walk.
// Ports: clk, rst_n (async low), bus (bpred_ctrl_if.slave). Option: BPRED_STATS_EN.
module bpred_ctrl #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3
) (
  input logic         clk,
  input logic         rst_n,
  bpred_ctrl_if.slave bus
);
  localparam int TAG_W = 10 - IDX_W;
  localparam logic [19:0] TEXT_HI = 20'h00400;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {IDLE, CLR} state_t;

  state_t state_q, state_d;

  logic [ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [11:0]        tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];
  logic [IDX_W-1:0]   ptr_q;

  logic             busy;
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic             if_ctrl, if_hit, ex_hit;
  logic             upd, far;
  logic             mispred;
  logic [31:0]      fix_pc;
  logic             redir_q;
  logic [31:0]      rpc_q;
  logic             unused_bits;

  assign unused_bits = ^{bus.if_inst[31:7], bus.if_inst[1:0]};

  always_comb begin
    if_ctrl = 1'b0;
    unique case (bus.if_inst[6:2])
      5'b11000, 5'b11011, 5'b11001: if_ctrl = 1'b1;
      default: if_ctrl = 1'b0;
    endcase
  end

  assign busy     = (state_q == CLR);
  assign bus.busy = busy;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign if_hit = if_ctrl && vld_q[if_idx]
               && tag_q[if_idx] == bus.if_pc[11:IDX_W+2]
               && bus.if_pc[31:12] == TEXT_HI
               && !busy;

  assign bus.predict_taken = if_hit && cnt_q[if_idx][1];
  assign bus.predict_pc = bus.predict_taken
                        ? {TEXT_HI, tgt_q[if_idx]}
                        : bus.if_pc + 32'd4;

  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign ex_hit = vld_q[ex_idx]
               && tag_q[ex_idx] == bus.ex_pc[11:IDX_W+2]
               && bus.ex_pc[31:12] == TEXT_HI;

  // Flush beats a same-cycle update; updates are also dropped mid-walk.
  assign upd = bus.ex_valid && !busy && !bus.flush_req;
  // Taken targets outside the text region cannot be stored in 12 bits.
  assign far = bus.ex_taken && bus.ex_target[31:12] != TEXT_HI;

  always_comb begin
    mispred = 1'b0;
    if (bus.ex_valid) begin
      if (bus.ex_is_ctrl)
        mispred = (bus.ex_taken != bus.ex_pred_taken)
               || (bus.ex_taken && bus.ex_pred_taken
                   && bus.ex_target != bus.ex_pred_pc);
      else
        mispred = bus.ex_pred_taken;
    end
  end

  assign fix_pc = (bus.ex_is_ctrl && bus.ex_taken)
                ? bus.ex_target
                : bus.ex_pc + 32'd4;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.flush_req) state_d = CLR;
      CLR:  if (ptr_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ptr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else if (busy) begin
      vld_q[ptr_q] <= 1'b0;
      ptr_q <= ptr_q + 1'b1;
    end else if (bus.flush_req) begin
      ptr_q <= '0;
    end else if (upd) begin
      if (!bus.ex_is_ctrl || far) begin
        if (ex_hit) vld_q[ex_idx] <= 1'b0;
      end else if (ex_hit) begin
        if (bus.ex_taken) begin
          tgt_q[ex_idx] <= bus.ex_target[11:0];
          if (cnt_q[ex_idx] != 2'd3)
            cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'd1;
        end else if (cnt_q[ex_idx] != 2'd0) begin
          cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'd1;
        end
      end else if (bus.ex_taken) begin
        vld_q[ex_idx] <= 1'b1;
        tag_q[ex_idx] <= bus.ex_pc[11:IDX_W+2];
        tgt_q[ex_idx] <= bus.ex_target[11:0];
        cnt_q[ex_idx] <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_q <= 1'b0;
      rpc_q   <= '0;
    end else begin
      redir_q <= mispred;
      if (mispred) rpc_q <= fix_pc;
    end
  end

  assign bus.redirect    = redir_q;
  assign bus.redirect_pc = rpc_q;

`ifdef BPRED_STATS_EN
  logic [15:0] br_q, mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (bus.ex_valid && bus.ex_is_ctrl && br_q != 16'hFFFF)
        br_q <= br_q + 16'd1;
      if (mispred && mp_q != 16'hFFFF)
        mp_q <= mp_q + 16'd1;
    end
  end

  assign bus.stat_branches    = br_q;
  assign bus.stat_mispredicts = mp_q;
`else
  assign bus.stat_branches    = '0;
  assign bus.stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_bpred_ctrl.sv
// tb_bpred_ctrl: vector table + scoreboard bench for bpred_ctrl.
// Checks lookup, update, redirect, clear walk, reset and stats.
module tb_bpred_ctrl;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;
  localparam logic [31:0] ADDI = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bpred_ctrl_if bus();

  bpred_ctrl #(.ENTRIES(8), .IDX_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ev;
    logic [31:0] epc;
    logic        ec;
    logic        et;
    logic [31:0] etgt;
    logic        ept;
    logic [31:0] eppc;
    logic        fl;
    logic        pt;
    logic [31:0] ppc;
    logic        rd;
    logic [31:0] rpc;
    logic        bz;
  } vec_t;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        bz;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int errors = 0;
  int checks = 0;
  int n_br = 0;
  int n_mp = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t lk(logic [31:0] pc, logic [31:0] inst,
                              logic pt, logic [31:0] ppc);
    vec_t v;
    v.pc = pc;   v.inst = inst;
    v.ev = 1'b0; v.epc = '0; v.ec = 1'b0; v.et = 1'b0;
    v.etgt = '0; v.ept = 1'b0; v.eppc = '0; v.fl = 1'b0;
    v.pt = pt;   v.ppc = ppc;
    v.rd = 1'b0; v.rpc = '0; v.bz = 1'b0;
    return v;
  endfunction

  function automatic vec_t ex(vec_t b, logic [31:0] epc, logic ec,
                              logic et, logic [31:0] etgt, logic ept,
                              logic [31:0] eppc, logic rd,
                              logic [31:0] rpc);
    b.ev = 1'b1; b.epc = epc; b.ec = ec; b.et = et;
    b.etgt = etgt; b.ept = ept; b.eppc = eppc;
    b.rd = rd; b.rpc = rpc;
    return b;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    bus.if_pc = v.pc;
    bus.if_inst = v.inst;
    bus.ex_valid = v.ev;
    bus.ex_pc = v.epc;
    bus.ex_is_ctrl = v.ec;
    bus.ex_taken = v.et;
    bus.ex_target = v.etgt;
    bus.ex_pred_taken = v.ept;
    bus.ex_pred_pc = v.eppc;
    bus.flush_req = v.fl;
    #1;
    chk({nm, ".ptaken"}, {31'd0, bus.predict_taken}, {31'd0, v.pt});
    chk({nm, ".ppc"}, bus.predict_pc, v.ppc);
    sb.push_back('{rd: v.rd, rpc: v.rpc, bz: v.bz});
    if (v.ev && v.ec) n_br++;
    if (v.rd) n_mp++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s.sb: got empty want entry", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".redir"}, {31'd0, bus.redirect}, {31'd0, e.rd});
      if (e.rd) chk({nm, ".rpc"}, bus.redirect_pc, e.rpc);
      chk({nm, ".busy"}, {31'd0, bus.busy}, {31'd0, e.bz});
    end
  endtask

  task automatic chk_stats(input string nm);
`ifdef BPRED_STATS_EN
    chk({nm, ".br"}, {16'd0, bus.stat_branches}, n_br);
    chk({nm, ".mp"}, {16'd0, bus.stat_mispredicts}, n_mp);
`else
    chk({nm, ".br"}, {16'd0, bus.stat_branches}, 32'd0);
    chk({nm, ".mp"}, {16'd0, bus.stat_mispredicts}, 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    tbl.push_back(lk(32'h0040000C, BEQ, 0, 32'h00400010));
    tbl.push_back(ex(lk(32'h0040000C, BEQ, 0, 32'h00400010),
      32'h0040000C, 1, 1, 32'h00400034, 0, 32'h00400010, 1, 32'h00400034));
    tbl.push_back(lk(32'h0040000C, BEQ, 1, 32'h00400034));
    tbl.push_back(ex(lk(32'h0040000C, BEQ, 1, 32'h00400034),
      32'h0040000C, 1, 0, 32'h00400034, 1, 32'h00400034, 1, 32'h00400010));
    tbl.push_back(lk(32'h0040000C, BEQ, 0, 32'h00400010));
    tbl.push_back(ex(lk(32'h0040000C, BEQ, 0, 32'h00400010),
      32'h0040000C, 1, 1, 32'h00400034, 0, 32'h00400010, 1, 32'h00400034));
    tbl.push_back(ex(lk(32'h0040000C, BEQ, 1, 32'h00400034),
      32'h0040000C, 1, 1, 32'h00400034, 1, 32'h00400034, 0, 32'h0));
    tbl.push_back(ex(lk(32'h0040000C, BEQ, 1, 32'h00400034),
      32'h0040000C, 1, 0, 32'h00400034, 1, 32'h00400034, 1, 32'h00400010));
    tbl.push_back(lk(32'h0040000C, BEQ, 1, 32'h00400034));
    tbl.push_back(ex(lk(32'h0040000C, BEQ, 1, 32'h00400034),
      32'h0040000C, 1, 1, 32'h00400050, 1, 32'h00400034, 1, 32'h00400050));
    tbl.push_back(lk(32'h0040000C, BEQ, 1, 32'h00400050));
    tbl.push_back(ex(lk(32'h00400024, BEQ, 0, 32'h00400028),
      32'h00400024, 1, 1, 32'h00400100, 0, 32'h00400028, 1, 32'h00400100));
    tbl.push_back(lk(32'h00400024, BEQ, 1, 32'h00400100));
    tbl.push_back(ex(lk(32'h00400024, BEQ, 1, 32'h00400100),
      32'h00400024, 0, 0, 32'h0, 1, 32'h00400100, 1, 32'h00400028));
    tbl.push_back(lk(32'h00400024, BEQ, 0, 32'h00400028));
    tbl.push_back(lk(32'h0040000C, ADDI, 0, 32'h00400010));
    tbl.push_back(ex(lk(32'h0040000C, BEQ, 1, 32'h00400050),
      32'h0040000C, 1, 1, 32'h00500000, 1, 32'h00400050, 1, 32'h00500000));
    tbl.push_back(lk(32'h0040000C, BEQ, 0, 32'h00400010));
    tbl.push_back(ex(lk(32'h0040000C, BEQ, 0, 32'h00400010),
      32'h0040000C, 1, 1, 32'h00400034, 0, 32'h00400010, 1, 32'h00400034));
    tbl.push_back(lk(32'h0040002C, BEQ, 0, 32'h00400030));
    tbl.push_back(lk(32'h0050000C, BEQ, 0, 32'h00500010));
    tbl.push_back(lk(32'h0040000C, JAL, 1, 32'h00400034));
    tbl.push_back(lk(32'h0040000C, JALR, 1, 32'h00400034));
    tbl.push_back(ex(lk(32'h0040000C, BEQ, 1, 32'h00400034),
      32'h00400040, 1, 0, 32'h00400080, 0, 32'h00400044, 0, 32'h0));
    tbl.push_back(lk(32'h00400040, BEQ, 0, 32'h00400044));
    v = ex(lk(32'h0040000C, BEQ, 1, 32'h00400034),
      32'h0040000C, 1, 1, 32'h00400090, 0, 32'h00400010, 0, 32'h0);
    v.ev = 1'b0;
    tbl.push_back(v);

    bus.if_pc = 32'h0040000C;
    bus.if_inst = BEQ;
    bus.ex_valid = 1'b0;
    bus.ex_pc = '0;
    bus.ex_is_ctrl = 1'b0;
    bus.ex_taken = 1'b0;
    bus.ex_target = '0;
    bus.ex_pred_taken = 1'b0;
    bus.ex_pred_pc = '0;
    bus.flush_req = 1'b0;
    #2;
    chk("rst.ptaken", {31'd0, bus.predict_taken}, 32'd0);
    chk("rst.ppc", bus.predict_pc, 32'h00400010);
    chk("rst.redir", {31'd0, bus.redirect}, 32'd0);
    chk("rst.rpc", bus.redirect_pc, 32'd0);
    chk("rst.busy", {31'd0, bus.busy}, 32'd0);
    chk_stats("rst");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));
    chk_stats("tbl");

    apply(ex(lk(32'h00400038, BEQ, 0, 32'h0040003C),
      32'h00400038, 1, 1, 32'h00400080, 0, 32'h0040003C, 1, 32'h00400080),
      "f0");
    v = ex(lk(32'h00400038, BEQ, 1, 32'h00400080),
      32'h00400044, 1, 1, 32'h00400090, 0, 32'h00400048, 1, 32'h00400090);
    v.fl = 1'b1;
    v.bz = 1'b1;
    apply(v, "f1");
    for (int k = 0; k < 8; k++) begin
      v = lk(32'h0040000C, BEQ, 0, 32'h00400010);
      if (k == 2)
        v = ex(v, 32'h00400060, 1, 1, 32'h004000A0, 0, 32'h00400064,
               1, 32'h004000A0);
      v.fl = (k == 1);
      v.bz = (k < 7);
      apply(v, $sformatf("clr%0d", k));
    end
    apply(lk(32'h0040000C, BEQ, 0, 32'h00400010), "a0");
    apply(lk(32'h00400038, BEQ, 0, 32'h0040003C), "a1");
    apply(lk(32'h00400044, BEQ, 0, 32'h00400048), "a2");
    apply(lk(32'h00400060, BEQ, 0, 32'h00400064), "a3");
    chk_stats("clr");

    apply(ex(lk(32'h0040000C, BEQ, 0, 32'h00400010),
      32'h0040000C, 1, 1, 32'h00400034, 0, 32'h00400010, 1, 32'h00400034),
      "r0");
    v = lk(32'h0040000C, BEQ, 1, 32'h00400034);
    v.fl = 1'b1;
    v.bz = 1'b1;
    apply(v, "r1");
    v = lk(32'h0040000C, BEQ, 0, 32'h00400010);
    v.bz = 1'b1;
    apply(v, "r2");
    chk_stats("prerst");

    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.busy", {31'd0, bus.busy}, 32'd0);
    chk("mrst.redir", {31'd0, bus.redirect}, 32'd0);
    chk("mrst.ptaken", {31'd0, bus.predict_taken}, 32'd0);
    chk("mrst.ppc", bus.predict_pc, 32'h00400010);
    n_br = 0;
    n_mp = 0;
    chk_stats("mrst");
    @(negedge clk);
    rst_n = 1'b1;
    apply(lk(32'h0040000C, BEQ, 0, 32'h00400010), "p0");
    apply(lk(32'h0040000C, BEQ, 0, 32'h00400010), "p1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
